csr_file: RTL and testbench

Machine/supervisor control-and-status register file for the multicycle RV32 core. Sits directly downstream of the ALU's CSR port, and also feeds it:
- Consumes CSR write commands (select/load/data) and ECALL/EBREAK exception pulses.
- Returns the selected CSR value plus the trap-related CSRs (status, epc, tvec).
- Owns the cycle/instret counters, interrupt-pending/enable logic and trap cause capture, and raises the M/S interrupt requests that the control FSM turns into the MINT/SINT states.

---
 rtl/riscv_csr_pkg.sv | 47 ++++
 rtl/csr_counter64.sv | 28 ++
 rtl/csr_file.sv | 162 ++++++++++++++++
 tb/tb_csr_file.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/riscv_csr_pkg.sv
// Shared CSR addresses, write masks, trap cause codes and the trap request state type.
package riscv_csr_pkg;

  localparam logic [11:0] CSR_SSTATUS   = 12'h100;
  localparam logic [11:0] CSR_SIE       = 12'h104;
  localparam logic [11:0] CSR_STVEC     = 12'h105;
  localparam logic [11:0] CSR_SSCRATCH  = 12'h140;
  localparam logic [11:0] CSR_SEPC      = 12'h141;
  localparam logic [11:0] CSR_SCAUSE    = 12'h142;
  localparam logic [11:0] CSR_SIP       = 12'h144;
  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MIE       = 12'h304;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MIP       = 12'h344;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
  localparam logic [11:0] CSR_CYCLE     = 12'hC00;
  localparam logic [11:0] CSR_INSTRET   = 12'hC02;
  localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
  localparam logic [11:0] CSR_INSTRETH  = 12'hC82;
  localparam logic [11:0] CSR_MHARTID   = 12'hF14;

  localparam logic [31:0] MSTATUS_MASK  = 32'h0000_1888;
  localparam logic [31:0] SSTATUS_MASK  = 32'h0000_0122;
  localparam logic [31:0] MIE_MASK      = 32'h0000_0888;
  localparam logic [31:0] MSTATUS_RESET = 32'h0000_1800;
  localparam logic [31:0] ALIGN4_MASK   = 32'hFFFF_FFFC;

  localparam logic [31:0] CAUSE_ECALL  = 32'h0000_000B;
  localparam logic [31:0] CAUSE_EBREAK = 32'h0000_0003;
  localparam logic [31:0] CAUSE_MEI    = 32'h8000_000B;
  localparam logic [31:0] CAUSE_MSI    = 32'h8000_0003;
  localparam logic [31:0] CAUSE_MTI    = 32'h8000_0007;
  localparam logic [31:0] CAUSE_SSI    = 32'h8000_0001;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_M_PEND = 2'd1,
    ST_S_PEND = 2'd2
  } trap_state_e;

endpackage

// File: rtl/csr_counter64.sv
// 64-bit counter with per-half software write; any write blocks that cycle's increment.
module csr_counter64 (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        en_i,
  input  logic        wr_lo_i,
  input  logic        wr_hi_i,
  input  logic [31:0] wdata_i,
  output logic [63:0] count_o
);

  logic [63:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (wr_lo_i) count_d[31:0] = wdata_i;
    if (wr_hi_i) count_d[63:32] = wdata_i;
    if (!wr_lo_i && !wr_hi_i && en_i) count_d = count_q + 64'd1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) count_q <= 64'd0;
    else       count_q <= count_d;
  end

  assign count_o = count_q;

endmodule

// File: rtl/csr_file.sv
// Machine/supervisor CSR file: register storage, counters, read mux and trap request FSM.
module csr_file
  import riscv_csr_pkg::*;
#(
  parameter logic [31:0] HART_ID = 32'd0
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [11:0] i_csr_select,
  input  logic        i_csr_load,
  input  logic [31:0] i_csr_data,
  output logic [31:0] o_csr_reg,
  output logic [31:0] o_mstatus,
  output logic [31:0] o_sstatus,
  output logic [31:0] o_mepc,
  output logic [31:0] o_sepc,
  output logic [31:0] o_mtvec,
  output logic [31:0] o_stvec,
  input  logic        i_exception_ecall,
  input  logic        i_exception_ebreak,
  input  logic        i_instr_retired,
  input  logic        i_ext_irq,
  input  logic        i_timer_irq,
  input  logic        i_interrupt_finnished,
  output logic        o_mint_req,
  output logic        o_sint_req
);

  logic [31:0] mstatus_q, sstatus_q, mie_q, mtvec_q, stvec_q, mepc_q, sepc_q;
  logic [31:0] mcause_q, scause_q, mscratch_q, sscratch_q;
  logic        msip_q, ssie_q, ssip_q;
  logic [31:0] cause_q, cause_d;
  trap_state_e state_q, state_d;
  logic [63:0] mcycle, minstret;
  logic [31:0] mip_view;

  assign mip_view = {20'd0, i_ext_irq, 3'd0, i_timer_irq, 3'd0, msip_q, 3'd0};

  csr_counter64 u_mcycle (
    .clk_i   (i_clk),
    .rst_i   (i_rst),
    .en_i    (1'b1),
    .wr_lo_i (i_csr_load && i_csr_select == CSR_MCYCLE),
    .wr_hi_i (i_csr_load && i_csr_select == CSR_MCYCLEH),
    .wdata_i (i_csr_data),
    .count_o (mcycle)
  );

  csr_counter64 u_minstret (
    .clk_i   (i_clk),
    .rst_i   (i_rst),
    .en_i    (i_instr_retired),
    .wr_lo_i (i_csr_load && i_csr_select == CSR_MINSTRET),
    .wr_hi_i (i_csr_load && i_csr_select == CSR_MINSTRETH),
    .wdata_i (i_csr_data),
    .count_o (minstret)
  );

  always_comb begin
    o_csr_reg = 32'd0;
    case (i_csr_select)
      CSR_MSTATUS:                 o_csr_reg = mstatus_q;
      CSR_SSTATUS:                 o_csr_reg = sstatus_q;
      CSR_MIE:                     o_csr_reg = mie_q;
      CSR_MIP:                     o_csr_reg = mip_view;
      CSR_SIE:                     o_csr_reg = {30'd0, ssie_q, 1'b0};
      CSR_SIP:                     o_csr_reg = {30'd0, ssip_q, 1'b0};
      CSR_MTVEC:                   o_csr_reg = mtvec_q;
      CSR_STVEC:                   o_csr_reg = stvec_q;
      CSR_MEPC:                    o_csr_reg = mepc_q;
      CSR_SEPC:                    o_csr_reg = sepc_q;
      CSR_MCAUSE:                  o_csr_reg = mcause_q;
      CSR_SCAUSE:                  o_csr_reg = scause_q;
      CSR_MSCRATCH:                o_csr_reg = mscratch_q;
      CSR_SSCRATCH:                o_csr_reg = sscratch_q;
      CSR_MCYCLE,    CSR_CYCLE:    o_csr_reg = mcycle[31:0];
      CSR_MCYCLEH,   CSR_CYCLEH:   o_csr_reg = mcycle[63:32];
      CSR_MINSTRET,  CSR_INSTRET:  o_csr_reg = minstret[31:0];
      CSR_MINSTRETH, CSR_INSTRETH: o_csr_reg = minstret[63:32];
      CSR_MHARTID:                 o_csr_reg = HART_ID;
      default:                     o_csr_reg = 32'd0;
    endcase
  end

  // Exceptions bypass MIE; the cause is frozen on entry until the ALU finishes the trap.
  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    case (state_q)
      ST_IDLE: begin
        if (i_exception_ecall) begin
          state_d = ST_M_PEND; cause_d = CAUSE_ECALL;
        end else if (i_exception_ebreak) begin
          state_d = ST_M_PEND; cause_d = CAUSE_EBREAK;
        end else if (mstatus_q[3] && mie_q[11] && i_ext_irq) begin
          state_d = ST_M_PEND; cause_d = CAUSE_MEI;
        end else if (mstatus_q[3] && mie_q[3] && msip_q) begin
          state_d = ST_M_PEND; cause_d = CAUSE_MSI;
        end else if (mstatus_q[3] && mie_q[7] && i_timer_irq) begin
          state_d = ST_M_PEND; cause_d = CAUSE_MTI;
        end else if (sstatus_q[1] && ssie_q && ssip_q) begin
          state_d = ST_S_PEND; cause_d = CAUSE_SSI;
        end
      end
      ST_M_PEND, ST_S_PEND: if (i_interrupt_finnished) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= ST_IDLE;
      cause_q    <= 32'd0;
      mstatus_q  <= MSTATUS_RESET;
      sstatus_q  <= 32'd0;
      mie_q      <= 32'd0;
      msip_q     <= 1'b0;
      ssie_q     <= 1'b0;
      ssip_q     <= 1'b0;
      mtvec_q    <= 32'd0;
      stvec_q    <= 32'd0;
      mepc_q     <= 32'd0;
      sepc_q     <= 32'd0;
      mcause_q   <= 32'd0;
      scause_q   <= 32'd0;
      mscratch_q <= 32'd0;
      sscratch_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      if (i_csr_load) begin
        case (i_csr_select)
          CSR_MSTATUS:  mstatus_q  <= i_csr_data & MSTATUS_MASK;
          CSR_SSTATUS:  sstatus_q  <= i_csr_data & SSTATUS_MASK;
          CSR_MIE:      mie_q      <= i_csr_data & MIE_MASK;
          CSR_MIP:      msip_q     <= i_csr_data[3];
          CSR_SIE:      ssie_q     <= i_csr_data[1];
          CSR_SIP:      ssip_q     <= i_csr_data[1];
          CSR_MTVEC:    mtvec_q    <= i_csr_data & ALIGN4_MASK;
          CSR_STVEC:    stvec_q    <= i_csr_data & ALIGN4_MASK;
          CSR_MEPC:     mepc_q     <= i_csr_data & ALIGN4_MASK;
          CSR_SEPC:     sepc_q     <= i_csr_data & ALIGN4_MASK;
          CSR_MSCRATCH: mscratch_q <= i_csr_data;
          CSR_SSCRATCH: sscratch_q <= i_csr_data;
          default: ;
        endcase
      end
      if (state_q == ST_M_PEND && i_interrupt_finnished) mcause_q <= cause_q;
      if (state_q == ST_S_PEND && i_interrupt_finnished) scause_q <= cause_q;
    end
  end

  assign o_mint_req = (state_q == ST_M_PEND);
  assign o_sint_req = (state_q == ST_S_PEND);
  assign o_mstatus  = mstatus_q;
  assign o_sstatus  = sstatus_q;
  assign o_mepc     = mepc_q;
  assign o_sepc     = sepc_q;
  assign o_mtvec    = mtvec_q;
  assign o_stvec    = stvec_q;

endmodule

// File: tb/tb_csr_file.sv
// Directed bench for csr_file: reset values, masks, counters and trap request sequencing.
module tb_csr_file;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] sel;
  logic        load;
  logic [31:0] wdata;
  logic [31:0] csr_reg, mstatus, sstatus, mepc, sepc, mtvec, stvec;
  logic        ecall, ebreak, retired, ext_irq, timer_irq, finished;
  logic        mint_req, sint_req;

  int n_assert = 0;
  int n_fail   = 0;

  localparam logic [31:0] HART = 32'h0000_0005;

  csr_file #(.HART_ID(HART)) dut (
    .i_clk                 (clk),
    .i_rst                 (rst),
    .i_csr_select          (sel),
    .i_csr_load            (load),
    .i_csr_data            (wdata),
    .o_csr_reg             (csr_reg),
    .o_mstatus             (mstatus),
    .o_sstatus             (sstatus),
    .o_mepc                (mepc),
    .o_sepc                (sepc),
    .o_mtvec               (mtvec),
    .o_stvec               (stvec),
    .i_exception_ecall     (ecall),
    .i_exception_ebreak    (ebreak),
    .i_instr_retired       (retired),
    .i_ext_irq             (ext_irq),
    .i_timer_irq           (timer_irq),
    .i_interrupt_finnished (finished),
    .o_mint_req            (mint_req),
    .o_sint_req            (sint_req)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
    $display("check %-14s observed %h expected %h", tag, obs, exp);
  endtask

  task automatic rd(input string tag, input logic [11:0] addr, input logic [31:0] exp);
    sel = addr;
    #1;
    chk(tag, csr_reg, exp);
  endtask

  task automatic wr(input logic [11:0] addr, input logic [31:0] data);
    sel = addr; wdata = data; load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  logic [11:0] addrs [23] = '{12'h300, 12'h100, 12'h304, 12'h344, 12'h104, 12'h144,
                              12'h305, 12'h105, 12'h341, 12'h141, 12'h342, 12'h142,
                              12'h340, 12'h140, 12'hB00, 12'hB80, 12'hB02, 12'hB82,
                              12'hC00, 12'hC80, 12'hC02, 12'hC82, 12'hF14};

  initial begin
    rst = 1'b1; sel = '0; load = 1'b0; wdata = '0;
    ecall = 0; ebreak = 0; retired = 0; ext_irq = 0; timer_irq = 0; finished = 0;
    tick(); tick(); tick();

    // Reset values, read while reset is still held so counters stay at zero
    for (int i = 0; i < 23; i++) begin
      logic [31:0] e;
      e = (addrs[i] == 12'h300) ? 32'h0000_1800 : (addrs[i] == 12'hF14) ? HART : 32'd0;
      rd($sformatf("rst_%h", addrs[i]), addrs[i], e);
    end
    chk("rst_mint", {31'd0, mint_req}, 32'd0);
    chk("rst_sint", {31'd0, sint_req}, 32'd0);
    tick();
    rst = 1'b0;

    // Write masks and read-only / unimplemented addresses
    wr(12'h300, 32'hFFFF_FFFF); rd("mstatus_mask", 12'h300, 32'h0000_1888);
    chk("o_mstatus", mstatus, 32'h0000_1888);
    wr(12'h305, 32'hFFFF_FFFF); rd("mtvec_mask", 12'h305, 32'hFFFF_FFFC);
    chk("o_mtvec", mtvec, 32'hFFFF_FFFC);
    wr(12'h341, 32'h0000_1003); chk("o_mepc", mepc, 32'h0000_1000);
    wr(12'h105, 32'h0000_0207); chk("o_stvec", stvec, 32'h0000_0204);
    wr(12'h100, 32'hFFFF_FFFF); rd("sstatus_mask", 12'h100, 32'h0000_0122);
    wr(12'h342, 32'h0000_00FF); rd("mcause_ro", 12'h342, 32'd0);
    wr(12'h7C0, 32'h0000_0055); rd("unimpl", 12'h7C0, 32'd0);
    wr(12'h340, 32'hDEAD_BEEF); rd("mscratch", 12'h340, 32'hDEAD_BEEF);
    wr(12'h304, 32'hFFFF_FFFF); rd("mie_mask", 12'h304, 32'h0000_0888);
    wr(12'h304, 32'd0);
    wr(12'h300, 32'd0);
    wr(12'h100, 32'd0);

    // Counters: ignored alias write, carry, write beats increment
    wr(12'hB00, 32'd100);
    wr(12'hC00, 32'h1234_5678);
    rd("cycle_ro", 12'hC00, 32'd101);
    rd("mcycle_101", 12'hB00, 32'd101);
    wr(12'hB80, 32'd0);
    wr(12'hB00, 32'hFFFF_FFFF);
    rd("mcycle_wr", 12'hB00, 32'hFFFF_FFFF);
    rd("mcycleh_0", 12'hB80, 32'd0);
    tick();
    rd("mcycle_wrap", 12'hB00, 32'd0);
    rd("mcycleh_carry", 12'hB80, 32'd1);
    tick();
    rd("mcycle_1", 12'hB00, 32'd1);
    rd("cycleh_1", 12'hC80, 32'd1);
    retired = 1'b1; tick(); tick(); retired = 1'b0;
    rd("instret_2", 12'hC02, 32'd2);
    wr(12'hB82, 32'd7);
    rd("minstreth_7", 12'hB82, 32'd7);
    rd("minstret_hold", 12'hB02, 32'd2);

    // ECALL trap
    ecall = 1'b1; tick(); ecall = 1'b0;
    chk("ecall_req", {31'd0, mint_req}, 32'd1);
    chk("ecall_sint", {31'd0, sint_req}, 32'd0);
    tick();
    chk("ecall_hold", {31'd0, mint_req}, 32'd1);
    finished = 1'b1; tick(); finished = 1'b0;
    chk("ecall_drop", {31'd0, mint_req}, 32'd0);
    rd("mcause_ecall", 12'h342, 32'd11);

    // EBREAK; ECALL while pending is dropped; mstatus write collides with finish
    ebreak = 1'b1; tick(); ebreak = 1'b0;
    chk("ebreak_req", {31'd0, mint_req}, 32'd1);
    ecall = 1'b1; tick(); ecall = 1'b0;
    sel = 12'h300; wdata = 32'h0000_0080; load = 1'b1; finished = 1'b1;
    tick();
    load = 1'b0; finished = 1'b0;
    rd("collide_mstat", 12'h300, 32'h0000_0080);
    rd("mcause_ebreak", 12'h342, 32'd3);
    tick();
    chk("ecall_dropped", {31'd0, mint_req}, 32'd0);

    // External interrupt gated by MIE
    wr(12'h304, 32'h0000_0800);
    ext_irq = 1'b1; tick(); tick();
    chk("ext_mie0", {31'd0, mint_req}, 32'd0);
    rd("mip_ext", 12'h344, 32'h0000_0800);
    wr(12'h300, 32'h0000_0008);
    chk("ext_wait", {31'd0, mint_req}, 32'd0);
    tick();
    chk("ext_req", {31'd0, mint_req}, 32'd1);
    tick();
    finished = 1'b1; ext_irq = 1'b0; tick(); finished = 1'b0;
    chk("ext_done", {31'd0, mint_req}, 32'd0);
    rd("mcause_mei", 12'h342, 32'h8000_000B);

    // External and timer together: priority, then timer alone
    wr(12'h304, 32'h0000_0880);
    ext_irq = 1'b1; timer_irq = 1'b1; tick();
    chk("both_req", {31'd0, mint_req}, 32'd1);
    tick();
    finished = 1'b1; ext_irq = 1'b0; tick(); finished = 1'b0;
    chk("both_done", {31'd0, mint_req}, 32'd0);
    rd("mcause_pri", 12'h342, 32'h8000_000B);
    tick();
    chk("timer_req", {31'd0, mint_req}, 32'd1);
    tick();
    finished = 1'b1; timer_irq = 1'b0; tick(); finished = 1'b0;
    rd("mcause_mti", 12'h342, 32'h8000_0007);
    chk("timer_done", {31'd0, mint_req}, 32'd0);

    // Supervisor software interrupt
    wr(12'h300, 32'd0);
    wr(12'h100, 32'h0000_0002);
    wr(12'h104, 32'h0000_0002);
    wr(12'h144, 32'h0000_0002);
    chk("ssi_wait", {31'd0, sint_req}, 32'd0);
    tick();
    chk("ssi_req", {31'd0, sint_req}, 32'd1);
    chk("ssi_nomint", {31'd0, mint_req}, 32'd0);
    tick();
    sel = 12'h144; wdata = 32'd0; load = 1'b1; finished = 1'b1;
    tick();
    load = 1'b0; finished = 1'b0;
    chk("ssi_done", {31'd0, sint_req}, 32'd0);
    rd("scause_ssi", 12'h142, 32'h8000_0001);
    rd("mcause_keep", 12'h342, 32'h8000_0007);

    // Reset in the middle of a request
    ecall = 1'b1; tick(); ecall = 1'b0;
    chk("mid_req", {31'd0, mint_req}, 32'd1);
    rst = 1'b1; tick();
    chk("mid_rst_req", {31'd0, mint_req}, 32'd0);
    rd("mid_rst_mcause", 12'h342, 32'd0);
    rd("mid_rst_cycle", 12'hB00, 32'd0);
    rd("mid_rst_mstat", 12'h300, 32'h0000_1800);
    rst = 1'b0;
    tick();
    rd("restart_cycle", 12'hB00, 32'd1);
    chk("restart_req", {31'd0, mint_req}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
